// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared types and constants for the stopwatch controller.
//   CS_W       : width of the centisecond count and the displayed value
//   MAX_CS     : 99:59.99 expressed in centiseconds; the count saturates here
//   sw_state_t : controller state encoding
//   is_running : true for the states in which time advances
// -----------------------------------------------------------------------------
package sw_pkg;

    localparam int CS_W = 20;
    localparam logic [CS_W-1:0] MAX_CS = 20'd599999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        LAP_RUN = 2'd2,
        STOPPED = 2'd3
    } sw_state_t;

    function automatic logic is_running(input sw_state_t s);
        return (s == RUN) || (s == LAP_RUN);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick every TICK_DIV enabled clocks.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   en       : count enable; the count holds its value while low
//   clr      : synchronous return to zero, wins over en
//   tick     : high for the cycle in which the count wraps TICK_DIV-1 -> 0
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = en && !clr && (r_cnt == LAST);
    assign tick   = w_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Centisecond stopwatch with start/stop, lap freeze and clear.
//   clk         : system clock, CLK_HZ
//   reset_n     : asynchronous active-low reset
//   start_stop  : one-cycle pulse, toggles running/stopped
//   lap         : one-cycle pulse, freezes/releases the displayed lap time
//   clear       : one-cycle pulse, zeroes everything when not running
//   value       : registered display value in centiseconds
//   running     : high in RUN or LAP_RUN
//   lap_active  : high in LAP_RUN
//   overflow    : sticky, set when the count saturates at MAX_CS
//
// state   | meaning
// IDLE    | cleared, nothing counting, prescaler held at zero
// RUN     | counting, display follows the elapsed count
// LAP_RUN | counting, display frozen on the captured lap time
// STOPPED | count and prescaler held, display shows the elapsed count
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import sw_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_stop,
    input  logic            lap,
    input  logic            clear,
    output logic [CS_W-1:0] value,
    output logic            running,
    output logic            lap_active,
    output logic            overflow
);

    localparam int TICK_DIV = CLK_HZ / 100;

    sw_state_t       r_state;
    sw_state_t       w_state_nxt;
    logic [CS_W-1:0] r_cs_cnt;
    logic [CS_W-1:0] r_lap_reg;
    logic [CS_W-1:0] r_value;
    logic            r_overflow;
    logic            r_running;
    logic            r_lap_active;

    logic            w_tick;
    logic            w_clear_fire;
    logic            w_ss_fire;
    logic            w_lap_fire;
    logic            w_lap_cap;
    logic            w_sat;
    logic            w_pre_en;
    logic            w_pre_clr;

    assign w_pre_en  = is_running(r_state);
    assign w_pre_clr = w_clear_fire || (r_state == IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_pre_en),
        .clr     (w_pre_clr),
        .tick    (w_tick)
    );

    // A raw clear or start_stop pulse masks the lower-priority pulses for the
    // cycle, even when the higher one has no effect in the current state.
    always_comb begin
        w_clear_fire = clear && ((r_state == IDLE) || (r_state == STOPPED));
        w_ss_fire    = start_stop && !clear;
        w_lap_fire   = lap && !clear && !start_stop && is_running(r_state);
        w_lap_cap    = w_lap_fire && (r_state == RUN);
        w_sat        = w_tick && (r_cs_cnt == MAX_CS);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_clear_fire)   w_state_nxt = IDLE;
                else if (w_ss_fire) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_ss_fire || w_sat) w_state_nxt = STOPPED;
                else if (w_lap_fire)    w_state_nxt = LAP_RUN;
            end
            LAP_RUN: begin
                if (w_ss_fire || w_sat) w_state_nxt = STOPPED;
                else if (w_lap_fire)    w_state_nxt = RUN;
            end
            STOPPED: begin
                if (w_clear_fire)   w_state_nxt = IDLE;
                else if (w_ss_fire) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they never glitch
    // on the two-bit RUN <-> LAP_RUN transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_running    <= is_running(w_state_nxt);
            r_lap_active <= (w_state_nxt == LAP_RUN);
        end
    end

    // The lap capture reads r_cs_cnt before this edge's increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_cnt   <= '0;
            r_lap_reg  <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear_fire) begin
            r_cs_cnt   <= '0;
            r_lap_reg  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_tick && !w_sat) r_cs_cnt <= r_cs_cnt + 1'b1;
            if (w_sat)            r_overflow <= 1'b1;
            if (w_lap_cap)        r_lap_reg <= r_cs_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else begin
            r_value <= (r_state == LAP_RUN) ? r_lap_reg : r_cs_cnt;
        end
    end

    assign value      = r_value;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl at CLK_HZ = 1000 (ten clocks per tick).
// Expectations are queued as each stimulus is applied and compared when the
// outputs are sampled on the falling edge. Edge numbers in the comments count
// rising edges from the edge that accepts the start pulse of each scenario.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int SEL_VAL = 0;
    localparam int SEL_RUN = 1;
    localparam int SEL_LAP = 2;
    localparam int SEL_OVF = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [19:0] value;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [19:0] exp;
    } exp_t;

    exp_t sb[$];

    stopwatch_ctrl #(
        .CLK_HZ (1000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .value      (value),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [19:0] observe(input int sel);
        case (sel)
            SEL_VAL: return value;
            SEL_RUN: return {19'd0, running};
            SEL_LAP: return {19'd0, lap_active};
            default: return {19'd0, overflow};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [19:0] e);
        exp_t item;
        item.tag = tag;
        item.sel = sel;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic drain();
        exp_t        item;
        logic [19:0] obs;
        while (sb.size() > 0) begin
            item = sb.pop_front();
            obs  = observe(item.sel);
            n_vec++;
            assert (obs === item.exp) else begin
                n_miss++;
                $error("FAIL %s: observed %0d expected %0d", item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; the pulse is seen by exactly one rising edge.
    task automatic pulse(input logic c, input logic s, input logic l);
        clear      = c;
        start_stop = s;
        lap        = l;
        @(negedge clk);
        clear      = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;

        // Reset state
        step(3);
        expect_out("rst_value",   SEL_VAL, 20'd0);
        expect_out("rst_running", SEL_RUN, 20'd0);
        expect_out("rst_lap",     SEL_LAP, 20'd0);
        expect_out("rst_ovf",     SEL_OVF, 20'd0);
        drain();

        // Release reset and start on the very next edge (P1).
        // Ticks land on P11, P21, ... so cs = 100 from P1001.
        reset_n = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        step(1004);
        expect_out("run1000_value",   SEL_VAL, 20'd100);
        expect_out("run1000_running", SEL_RUN, 20'd1);
        expect_out("run1000_lap",     SEL_LAP, 20'd0);
        drain();

        // Clear while running is ignored (edge P1006).
        pulse(1'b1, 1'b0, 1'b0);
        step(1);
        expect_out("clr_in_run_value",   SEL_VAL, 20'd100);
        expect_out("clr_in_run_running", SEL_RUN, 20'd1);
        drain();

        // Stop, then clear and start_stop together: clear wins.
        pulse(1'b0, 1'b1, 1'b0);
        step(1);
        expect_out("stop_running", SEL_RUN, 20'd0);
        expect_out("stop_value",   SEL_VAL, 20'd100);
        drain();
        pulse(1'b1, 1'b1, 1'b0);
        step(1);
        expect_out("clr_prio_value",   SEL_VAL, 20'd0);
        expect_out("clr_prio_running", SEL_RUN, 20'd0);
        expect_out("clr_prio_ovf",     SEL_OVF, 20'd0);
        drain();

        // Lap in IDLE has no effect.
        pulse(1'b0, 1'b0, 1'b1);
        step(1);
        expect_out("lap_idle_lap",     SEL_LAP, 20'd0);
        expect_out("lap_idle_running", SEL_RUN, 20'd0);
        expect_out("lap_idle_value",   SEL_VAL, 20'd0);
        drain();

        // Stop/resume: start at Q1, stop at Q56 with cs = 5 and prescaler = 5.
        pulse(1'b0, 1'b1, 1'b0);
        step(54);
        pulse(1'b0, 1'b1, 1'b0);
        step(1);
        expect_out("stop55_value",   SEL_VAL, 20'd5);
        expect_out("stop55_running", SEL_RUN, 20'd0);
        drain();
        // Resume at R1 with the prescaler still at 5: ticks at R6, R16 ... R46,
        // so cs = 10 at R46. A prescaler reset on resume would leave cs = 9.
        pulse(1'b0, 1'b1, 1'b0);
        step(47);
        expect_out("resume_value", SEL_VAL, 20'd10);
        drain();

        // From R46 cs = 10 + k at R(46+10k): 42 over R366..R375, 70 over R646..R655.
        step(321);
        pulse(1'b0, 1'b0, 1'b1);                 // lap at R370
        step(30);
        expect_out("lap42_value",   SEL_VAL, 20'd42);
        expect_out("lap42_lap",     SEL_LAP, 20'd1);
        expect_out("lap42_running", SEL_RUN, 20'd1);
        drain();
        step(249);
        pulse(1'b0, 1'b0, 1'b1);                 // release at R650
        expect_out("lap_release_held", SEL_VAL, 20'd42);
        drain();
        step(1);
        expect_out("lap70_value", SEL_VAL, 20'd70);
        expect_out("lap70_lap",   SEL_LAP, 20'd0);
        drain();

        // Lap on a tick edge (R656) captures the pre-increment count.
        step(4);
        pulse(1'b0, 1'b0, 1'b1);
        step(2);
        expect_out("lap_tick_value", SEL_VAL, 20'd70);
        expect_out("lap_tick_lap",   SEL_LAP, 20'd1);
        drain();

        // LAP_RUN -> STOPPED shows the live count again.
        pulse(1'b0, 1'b1, 1'b0);
        step(1);
        expect_out("lapstop_value",   SEL_VAL, 20'd71);
        expect_out("lapstop_running", SEL_RUN, 20'd0);
        expect_out("lapstop_lap",     SEL_LAP, 20'd0);
        drain();

        // Overflow: clear, preload MAX_CS-1 while idle, start at S1.
        // Ticks at S11 (599999) and S21 (saturate, stop).
        pulse(1'b1, 1'b0, 1'b0);
        dut.r_cs_cnt = 20'd599998;
        step(2);
        expect_out("preload_value", SEL_VAL, 20'd599998);
        drain();
        pulse(1'b0, 1'b1, 1'b0);
        step(25);
        expect_out("ovf_value",   SEL_VAL, 20'd599999);
        expect_out("ovf_flag",    SEL_OVF, 20'd1);
        expect_out("ovf_running", SEL_RUN, 20'd0);
        expect_out("ovf_lap",     SEL_LAP, 20'd0);
        drain();
        pulse(1'b0, 1'b1, 1'b0);
        step(3);
        expect_out("ovf_sticky",       SEL_OVF, 20'd1);
        expect_out("ovf_resume_value", SEL_VAL, 20'd599999);
        drain();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        step(1);
        expect_out("ovf_clear_flag",  SEL_OVF, 20'd0);
        expect_out("ovf_clear_value", SEL_VAL, 20'd0);
        drain();

        // Async reset during LAP_RUN: cs = 3 at the lap, so the display is 3.
        pulse(1'b0, 1'b1, 1'b0);
        step(35);
        pulse(1'b0, 1'b0, 1'b1);
        step(3);
        expect_out("pre_rst_lap",   SEL_LAP, 20'd1);
        expect_out("pre_rst_value", SEL_VAL, 20'd3);
        drain();
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("async_rst_value",   SEL_VAL, 20'd0);
        expect_out("async_rst_running", SEL_RUN, 20'd0);
        expect_out("async_rst_lap",     SEL_LAP, 20'd0);
        expect_out("async_rst_ovf",     SEL_OVF, 20'd0);
        drain();
        step(3);
        reset_n = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("post_rst_running", SEL_RUN, 20'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
